// File: rtl/program_loader_pkg.sv
// Shared constants for the program loader: default widths, memory size and FSM encodings.
// Also imported by the data-path RAM so that its depth and the loader address range agree.
package program_loader_pkg;
  localparam int LDR_ADDR_WIDTH = 9;
  localparam int LDR_DATA_WIDTH = 8;
  localparam int LDR_START_ADDR = 0;
  localparam int LDR_MEM_BYTES  = 1 << LDR_ADDR_WIDTH;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_DONE  = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;
endpackage

// File: rtl/program_loader.sv
// Streams program bytes into the data-path RAM; write port is registered (1 cycle after accept).
// Backpressure: in_ready is high only while loading; it drops once the load finishes or overflows.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = LDR_ADDR_WIDTH,
  parameter int DATA_WIDTH = LDR_DATA_WIDTH,
  parameter int START_ADDR = LDR_START_ADDR
) (
  input  logic                  main_clk,
  input  logic                  reset,
  input  logic                  reload,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  overflow_err,
  output logic [ADDR_WIDTH:0]   byte_count
);
  localparam logic [ADDR_WIDTH-1:0] START_PTR = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = '1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  xfer;

  assign in_ready = (state_q == ST_LOAD);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          data_d = in_data;
          cnt_d  = cnt_q + 1'b1;
          // The pointer saturates at the top of memory rather than wrapping onto the program start.
          if (ptr_q != LAST_PTR) ptr_d = ptr_q + 1'b1;
          if (in_last) state_d = ST_DONE;
          else if (ptr_q == LAST_PTR) state_d = ST_ERROR;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (reload) begin
          state_d = ST_LOAD;
          ptr_d   = START_PTR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
    // Released one cycle into DONE so the final registered write lands before the CPU runs.
    cpu_rst_d = !((state_q == ST_DONE) && !reload);
  end

  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_LOAD;
      ptr_q     <= START_PTR;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= START_PTR;
      data_q    <= '0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;
  assign cpu_reset    = cpu_rst_q;
  assign done         = (state_q == ST_DONE);
  assign overflow_err = (state_q == ST_ERROR);
  assign byte_count   = cnt_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: vector table for normal/reload/handshake traffic,
// plus hand-written overflow and asynchronous-reset sequences.
module tb_program_loader;
  typedef struct packed {
    logic       rdy;
    logic       we;
    logic [8:0] addr;
    logic [7:0] data;
    logic       cpu;
    logic       dn;
    logic       ov;
    logic [9:0] cnt;
  } outs_t;

  typedef struct {
    logic       rl;
    logic       v;
    logic [7:0] d;
    logic       l;
    outs_t      e;
  } vec_t;

  logic       main_clk, reset, reload, in_valid, in_last;
  logic [7:0] in_data;
  logic       in_ready, mem_we, cpu_reset, done, overflow_err;
  logic [8:0] mem_addr;
  logic [7:0] mem_data;
  logic [9:0] byte_count;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  logic [7:0] ram [0:511];

  program_loader dut (
    .main_clk(main_clk), .reset(reset), .reload(reload),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_reset(cpu_reset), .done(done), .overflow_err(overflow_err), .byte_count(byte_count)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  // Shadow RAM and write-pulse counter
  always @(posedge main_clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_data;
      we_cnt <= we_cnt + 1;
    end
  end

  function automatic outs_t mk(input logic r, input logic we, input logic [8:0] a,
                               input logic [7:0] d, input logic c, input logic dn,
                               input logic ov, input logic [9:0] n);
    outs_t o;
    o = '{rdy: r, we: we, addr: a, data: d, cpu: c, dn: dn, ov: ov, cnt: n};
    return o;
  endfunction

  task automatic step();
    @(posedge main_clk);
    #1;
  endtask

  task automatic chk(input string nm, input outs_t ex);
    outs_t act;
    act = '{rdy: in_ready, we: mem_we, addr: mem_addr, data: mem_data,
            cpu: cpu_reset, dn: done, ov: overflow_err, cnt: byte_count};
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got rdy=%b we=%b addr=%0d data=%h cpu=%b done=%b ovf=%b cnt=%0d, expected rdy=%b we=%b addr=%0d data=%h cpu=%b done=%b ovf=%b cnt=%0d",
               nm, act.rdy, act.we, act.addr, act.data, act.cpu, act.dn, act.ov, act.cnt,
               ex.rdy, ex.we, ex.addr, ex.data, ex.cpu, ex.dn, ex.ov, ex.cnt);
    end
  endtask

  task automatic chk_v(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, ex);
    end
  endtask

  localparam int NV = 15;
  vec_t vecs [NV];
  int   we_base;

  initial begin
    //             rl    v     data   last  rdy  we   addr   data   cpu  dn   ov   cnt
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, mk(1, 0, 9'd0, 8'h00, 1, 0, 0, 10'd0)};
    vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, mk(1, 1, 9'd0, 8'h11, 1, 0, 0, 10'd1)};
    vecs[2]  = '{1'b0, 1'b1, 8'h22, 1'b0, mk(1, 1, 9'd1, 8'h22, 1, 0, 0, 10'd2)};
    vecs[3]  = '{1'b0, 1'b1, 8'h33, 1'b1, mk(0, 1, 9'd2, 8'h33, 1, 1, 0, 10'd3)};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, mk(0, 0, 9'd2, 8'h33, 0, 1, 0, 10'd3)};
    vecs[5]  = '{1'b0, 1'b1, 8'h44, 1'b1, mk(0, 0, 9'd2, 8'h33, 0, 1, 0, 10'd3)};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, mk(1, 0, 9'd2, 8'h33, 1, 0, 0, 10'd0)};
    vecs[7]  = '{1'b0, 1'b1, 8'hAA, 1'b0, mk(1, 1, 9'd0, 8'hAA, 1, 0, 0, 10'd1)};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, mk(1, 0, 9'd0, 8'hAA, 1, 0, 0, 10'd1)};
    vecs[9]  = '{1'b0, 1'b1, 8'hB1, 1'b0, mk(1, 1, 9'd1, 8'hB1, 1, 0, 0, 10'd2)};
    vecs[10] = '{1'b0, 1'b0, 8'hFF, 1'b1, mk(1, 0, 9'd1, 8'hB1, 1, 0, 0, 10'd2)};
    vecs[11] = '{1'b0, 1'b1, 8'hB2, 1'b0, mk(1, 1, 9'd2, 8'hB2, 1, 0, 0, 10'd3)};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, mk(1, 0, 9'd2, 8'hB2, 1, 0, 0, 10'd3)};
    vecs[13] = '{1'b0, 1'b1, 8'hB3, 1'b1, mk(0, 1, 9'd3, 8'hB3, 1, 1, 0, 10'd4)};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, mk(0, 0, 9'd3, 8'hB3, 0, 1, 0, 10'd4)};

    reset = 1'b1; reload = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    #1;
    chk("reset_state", mk(1, 0, 9'd0, 8'h00, 1, 0, 0, 10'd0));
    step();
    step();
    reset = 1'b0;

    we_base = 0;
    for (int k = 0; k < NV; k++) begin
      reload = vecs[k].rl; in_valid = vecs[k].v; in_data = vecs[k].d; in_last = vecs[k].l;
      step();
      chk($sformatf("vec%0d", k), vecs[k].e);
      if (k == 6) we_base = we_cnt;
    end
    reload = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk_v("toggle_we_pulses", 32'(we_cnt - we_base), 32'd4);
    chk_v("ram0_after_reload", {24'd0, ram[0]}, 32'hAA);
    chk_v("ram3_last_byte", {24'd0, ram[3]}, 32'hB3);

    // Overflow: 512 bytes with in_last never set
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 512; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_last = 1'b0;
      step();
      if (i == 510) chk("ovf_byte510", mk(1, 1, 9'd510, 8'hFE, 1, 0, 0, 10'd511));
      if (i == 511) chk("ovf_byte511", mk(0, 1, 9'd511, 8'hFF, 1, 0, 1, 10'd512));
    end
    in_valid = 1'b1; in_data = 8'h00;
    step();
    chk("ovf_hold", mk(0, 0, 9'd511, 8'hFF, 1, 0, 1, 10'd512));
    in_valid = 1'b0;
    step();
    chk_v("ram511", {24'd0, ram[511]}, 32'hFF);

    // Asynchronous reset after 2 of 5 bytes
    reset = 1'b1;
    #1;
    reset = 1'b0;
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0;
    step();
    in_data = 8'h02;
    step();
    chk("mid_load_byte2", mk(1, 1, 9'd1, 8'h02, 1, 0, 0, 10'd2));
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("async_reset", mk(1, 0, 9'd0, 8'h00, 1, 0, 0, 10'd0));
    reset = 1'b0;
    #1;
    chk_v("ready_after_reset", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = 8'h5C; in_last = 1'b1;
    step();
    chk("restart_write", mk(0, 1, 9'd0, 8'h5C, 1, 1, 0, 10'd1));
    in_valid = 1'b0; in_last = 1'b0;
    step();
    chk_v("ram0_restart", {24'd0, ram[0]}, 32'h5C);
    chk_v("cpu_released", {31'd0, cpu_reset}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
